// File: rtl/round_timer_if.sv
// Control and display bundle for the countdown round timer.
// The game FSM drives the master side and the timer implements the slave side.
interface round_timer_if;
    logic       load;
    logic [5:0] load_val;
    logic       start;
    logic       pause;
    logic [5:0] remaining;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       warning;
    logic       expired;
    logic       expired_pulse;

    modport master (
        output load, load_val, start, pause,
        input  remaining, tens, ones, running, warning, expired, expired_pulse
    );

    modport slave (
        input  load, load_val, start, pause,
        output remaining, tens, ones, running, warning, expired, expired_pulse
    );
endinterface

// File: rtl/round_timer.sv
// Countdown game-round timer. It loads a round length and counts down once per
// clk_1hz edge while running. It keeps binary and BCD copies of the remaining
// time in step with each other, and flags the warning window and expiry.
module round_timer #(
    parameter int unsigned DEFAULT_SECS = 60,
    parameter int unsigned WARN_SECS    = 10
) (
    input logic          clk_1hz,
    input logic          rst_n,
    round_timer_if.slave bus
);
    localparam logic [5:0] DefSecs = 6'(DEFAULT_SECS);
    localparam logic [5:0] WarnSecs = 6'(WARN_SECS);
    localparam logic [3:0] DefTens = 4'(DEFAULT_SECS / 10);
    localparam logic [3:0] DefOnes = 4'(DEFAULT_SECS % 10);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e     r_state;
    logic [5:0] r_remaining;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_running;
    logic       r_warning;
    logic       r_expired;
    logic       r_expired_pulse;

    logic [5:0] w_load_secs;
    logic [5:0] w_load_rest;
    logic [3:0] w_load_tens;
    logic [3:0] w_load_ones;

    state_e     w_state_nxt;
    logic [5:0] w_rem_nxt;
    logic [3:0] w_tens_nxt;
    logic [3:0] w_ones_nxt;
    logic       w_pulse_nxt;

    // Convert the value being loaded to BCD by repeated compare/subtract-10.
    always_comb begin
        w_load_secs = (bus.load_val == 6'd0) ? DefSecs : bus.load_val;
        w_load_rest = w_load_secs;
        w_load_tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (w_load_rest >= 6'd10) begin
                w_load_rest = w_load_rest - 6'd10;
                w_load_tens = w_load_tens + 4'd1;
            end
        end
        w_load_ones = w_load_rest[3:0];
    end

    // Next state and next count. The input priority is load, then start & pause, then start,
    // then pause.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_pulse_nxt = 1'b0;
        if (bus.load) begin
            w_state_nxt = StIdle;
            w_rem_nxt   = w_load_secs;
            w_tens_nxt  = w_load_tens;
            w_ones_nxt  = w_load_ones;
        end else begin
            unique case (r_state)
                StIdle, StPause: begin
                    if (bus.start && !bus.pause) w_state_nxt = StRun;
                end
                StRun: begin
                    if (bus.pause && !bus.start) begin
                        w_state_nxt = StPause;
                    end else if (r_remaining <= 6'd1) begin
                        // Saturate at zero so the count never wraps to 63.
                        w_state_nxt = StDone;
                        w_rem_nxt   = 6'd0;
                        w_tens_nxt  = 4'd0;
                        w_ones_nxt  = 4'd0;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_rem_nxt = r_remaining - 6'd1;
                        if (r_ones == 4'd0) begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = r_tens - 4'd1;
                        end else begin
                            w_ones_nxt = r_ones - 4'd1;
                        end
                    end
                end
                StDone: ;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Register the state, the count and all flags. The flags come from the next-state
    // values, so each one changes on the same edge as the count.
    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= StIdle;
            r_remaining     <= DefSecs;
            r_tens          <= DefTens;
            r_ones          <= DefOnes;
            r_running       <= 1'b0;
            r_warning       <= 1'b0;
            r_expired       <= 1'b0;
            r_expired_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_remaining     <= w_rem_nxt;
            r_tens          <= w_tens_nxt;
            r_ones          <= w_ones_nxt;
            r_running       <= (w_state_nxt == StRun);
            r_warning       <= ((w_state_nxt == StRun) || (w_state_nxt == StPause)) &&
                               (w_rem_nxt != 6'd0) && (w_rem_nxt <= WarnSecs);
            r_expired       <= (w_state_nxt == StDone);
            r_expired_pulse <= w_pulse_nxt;
        end
    end

    assign bus.remaining     = r_remaining;
    assign bus.tens          = r_tens;
    assign bus.ones          = r_ones;
    assign bus.running       = r_running;
    assign bus.warning       = r_warning;
    assign bus.expired       = r_expired;
    assign bus.expired_pulse = r_expired_pulse;
endmodule
